mcs4_ram_seq: RTL
=================

MCS4_RAM_SEQ -- requirements
Module: mcs4_ram_seq

Interface
REQ-001 SHALL have parameter SRC_CACHE, default 1: 1 means the SRC cycle is skipped when the command address equals the last address sent; 0 means an SRC cycle is always issued.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid  in  1  host command offered.
REQ-005 SHALL have port cmd_ready  out  1  command accepted on a clk edge where cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_opa  in  4  I/O-RAM opcode (mcs4::ioram_opa_t encoding).
REQ-007 SHALL have port cmd_addr  in  8  SRC address: chip[7:6], reg[5:4], char[3:0].
REQ-008 SHALL have port cmd_wdata  in  4  write data for write-class opcodes.
REQ-009 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_data  out  4  read result; valid only while rsp_valid is high.
REQ-011 SHALL have port sync  out  1  instruction-cycle marker to the RAM chips.
REQ-012 SHALL have port cm_ram  out  1  RAM command line.
REQ-013 SHALL have port dbus_out  out  4  data bus driven toward the RAM dbus_in.
REQ-014 SHALL have port dbus_in  in  4  OR of all RAM dbus_out signals (0 when no chip drives).

Function
REQ-015 SHALL run a free-running phase counter A1,A2,A3,M1,M2,X1,X2,X3 (0..7), wrapping from X3 to A1, with sync=1 exactly in X3.
REQ-016 SHALL place the counter in X2 during reset, so the first cycle after release is X3 (sync=1) and the next is A1.
REQ-017 SHALL drive sync, cm_ram and dbus_out from registers, with no combinational path from host inputs to bus outputs.
REQ-018 SHALL drive idle/NOP instruction cycles with cm_ram=0 and dbus_out=0 in every phase.
REQ-019 SHALL use FSM states IDLE, PEND, SRC, IO: accept -> PEND; at the next A1 go to SRC, or to IO if the SRC is skipped; SRC -> IO at A1; IO -> IDLE after X3, or -> PEND on a back-to-back accept.
REQ-020 SHALL assert cmd_ready in IDLE and PEND-free states, and also in the X3 cycle of an IO cycle; otherwise cmd_ready=0.
REQ-021 SHALL latch opa, addr and wdata on accept; an accept in an X3 cycle SHALL start at the immediately following A1, with no idle instruction cycle.
REQ-022 SHALL drive the SRC cycle as M1 dbus=4'h2; X2 cm_ram=1, dbus=addr[7:4]; X3 cm_ram=0, dbus=addr[3:0]; all other phases 0.
REQ-023 SHALL drive the IO cycle as M1 dbus=4'hE; M2 cm_ram=1, dbus=opa; X2 cm_ram=0, with dbus=wdata for write-class (opa 0-7) or 0 for read-class (opa 8-F); all other phases 0.
REQ-024 SHALL capture dbus_in on the edge ending IO X2 for read-class opcodes.
REQ-025 SHALL pulse rsp_valid during IO X3, with rsp_data = the captured value for read-class opcodes or 0 for write-class.
REQ-026 SHALL hold registers last_addr and last_ok, set on completion of an SRC cycle's X3.
REQ-027 SHALL, when SRC_CACHE=1 and last_ok=1 and addr==last_addr, skip the SRC cycle.
REQ-028 SHALL give a latency from the accept edge (in X3) to rsp_valid of 16 cycles with SRC, or 8 cycles with SRC skipped; for an accept in another phase, the wait to the next A1 is added.
REQ-029 SHALL ignore cmd_valid while cmd_ready=0; the host holds its fields stable until accepted.

Reset
REQ-030 SHALL, while rst=1, force the FSM to IDLE and sync=0, cm_ram=0, dbus_out=0, cmd_ready=0, rsp_valid=0, rsp_data=0 and last_ok=0.
REQ-031 SHALL, when reset is asserted mid-command, drop the command with no rsp_valid, and the next command after release SHALL issue an SRC cycle.

Verification
REQ-032 SHALL cover reset release: sync=1 in the first cycle after release and every 8th cycle thereafter; cm_ram=0 and dbus_out=0 while idle.
REQ-033 SHALL cover WRM (opa 0) at addr 0x25, wdata 9, driven into an i4002 with RAM_ID=0: SRC X2 cm_ram=1/dbus=2, X3 dbus=5; IO M1 dbus=E, M2 cm_ram=1/dbus=0, X2 dbus=9; rsp_valid in IO X3 with rsp_data=0.
REQ-034 SHALL cover a following RDM (opa 9) at 0x25 with SRC_CACHE=1: no SRC cycle, rsp_valid 8 cycles after the X3 accept, rsp_data=9.
REQ-035 SHALL cover back-to-back commands with cmd_valid held: the second is accepted in X3 of the first IO cycle and its cycle starts at the next A1, with no NOP cycle between.
REQ-036 SHALL cover rst asserted during IO M2: outputs go to 0 at once, no rsp_valid; after release the same-address command still issues an SRC cycle.
REQ-037 SHALL cover SRC_CACHE=0 with two commands to 0x25: an SRC cycle precedes each IO cycle.

Source files
------------

// File: rtl/mcs4_ram_seq.sv
// Host-command sequencer for MCS-4 I/O-RAM chips: runs the 8-phase instruction
// cycle and emits an optional SRC cycle followed by one I/O cycle per command.
module mcs4_ram_seq #(
  parameter int SRC_CACHE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opa,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       sync,
  output logic       cm_ram,
  output logic [3:0] dbus_out,
  input  logic [3:0] dbus_in
);

  typedef enum logic [1:0] {IDLE, PEND, SRC, IO} state_e;

  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  state_e     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] opa_q, opa_d, wdata_q, wdata_d;
  logic [7:0] addr_q, addr_d, last_addr_q, last_addr_d;
  logic       last_ok_q, last_ok_d;
  logic       sync_q, sync_d, cm_q, cm_d, rdy_q, rdy_d, rv_q, rv_d;
  logic [3:0] dbus_q, dbus_d, rd_q, rd_d;
  logic       accept, skip;
  state_e     start_st;

  always_comb begin
    phase_d     = phase_q + 3'd1;
    accept      = cmd_valid && rdy_q;
    opa_d       = accept ? cmd_opa   : opa_q;
    addr_d      = accept ? cmd_addr  : addr_q;
    wdata_d     = accept ? cmd_wdata : wdata_q;
    skip        = (SRC_CACHE != 0) && last_ok_q && (addr_d == last_addr_q);
    start_st    = skip ? IO : SRC;
    state_d     = state_q;
    last_addr_d = last_addr_q;
    last_ok_d   = last_ok_q;

    // Transitions happen on the X3->A1 edge; an accept in X3 starts without a gap.
    case (state_q)
      IDLE: if (accept) state_d = (phase_q == PH_X3) ? start_st : PEND;
      PEND: if (phase_q == PH_X3) state_d = start_st;
      SRC: if (phase_q == PH_X3) begin
        state_d     = IO;
        last_addr_d = addr_q;
        last_ok_d   = 1'b1;
      end
      IO: if (phase_q == PH_X3) state_d = accept ? start_st : IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered: decode the cycle we are about to enter.
    cm_d   = 1'b0;
    dbus_d = 4'h0;
    if (state_d == SRC) begin
      case (phase_d)
        PH_M1: dbus_d = 4'h2;
        PH_X2: begin cm_d = 1'b1; dbus_d = addr_d[7:4]; end
        PH_X3: dbus_d = addr_d[3:0];
        default: ;
      endcase
    end else if (state_d == IO) begin
      case (phase_d)
        PH_M1: dbus_d = 4'hE;
        PH_M2: begin cm_d = 1'b1; dbus_d = opa_d; end
        PH_X2: dbus_d = opa_d[3] ? 4'h0 : wdata_d;
        default: ;
      endcase
    end

    sync_d = (phase_d == PH_X3);
    rdy_d  = (state_d == IDLE) || ((state_d == IO) && (phase_d == PH_X3));
    rv_d   = (state_q == IO) && (phase_q == PH_X2);
    rd_d   = (rv_d && opa_q[3]) ? dbus_in : 4'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_X2;
      opa_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_addr_q <= '0;
      last_ok_q   <= 1'b0;
      sync_q      <= 1'b0;
      cm_q        <= 1'b0;
      dbus_q      <= '0;
      rdy_q       <= 1'b0;
      rv_q        <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      opa_q       <= opa_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_addr_q <= last_addr_d;
      last_ok_q   <= last_ok_d;
      sync_q      <= sync_d;
      cm_q        <= cm_d;
      dbus_q      <= dbus_d;
      rdy_q       <= rdy_d;
      rv_q        <= rv_d;
      rd_q        <= rd_d;
    end
  end

  assign sync      = sync_q;
  assign cm_ram    = cm_q;
  assign dbus_out  = dbus_q;
  assign cmd_ready = rdy_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;

endmodule
